comb_row_reader: RTL and testbench

Drains the combination-stage result buffer (feature matrix × weight matrix product) one row at a time and streams each row to the aggregation stage over a valid/ready handshake. It is the read-side counterpart of the combination row counter that indexes rows as they are written. It reads a row only after the writer reports it complete. A 2-entry output FIFO hides the buffer's 1-cycle read latency, so a row can be delivered every cycle.

---
 rtl/comb_pkg.sv | 30 +++
 rtl/comb_row_fifo.sv | 59 +++++
 rtl/comb_row_reader.sv | 135 +++++++++++++
 tb/tb_comb_row_reader.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/comb_pkg.sv
// ============================================================================
// Module      : comb_pkg
// Description : Shared types for the combination-stage row reader and FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package comb_pkg;

  // Row geometry of the combination result buffer (product rows x elements).
  localparam int COMB_NUM_ROWS       = 6;
  localparam int COMB_IDX_W          = $clog2(COMB_NUM_ROWS);
  localparam int COMB_WM_NUM_OF_COLS = 3;
  localparam int COMB_DOT_PROD_WIDTH = 16;
  localparam int COMB_ROW_W          = COMB_WM_NUM_OF_COLS * COMB_DOT_PROD_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } comb_rd_state_t;

  typedef struct packed {
    logic [COMB_ROW_W-1:0] data;
    logic [COMB_IDX_W-1:0] idx;
  } comb_row_t;

endpackage : comb_pkg

`default_nettype wire

// File: rtl/comb_row_fifo.sv
// ============================================================================
// Module      : comb_row_fifo
// Description : 2-entry synchronous FIFO of comb_row_t used at stage boundaries.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module comb_row_fifo
  import comb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_push,
  input  comb_row_t  i_push_row,
  input  logic       i_pop,
  output comb_row_t  o_head,
  output logic [1:0] o_count
);

  comb_row_t  r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;
  logic       w_push;
  logic       w_pop;

  // A push into a full FIFO is only taken when the head leaves the same cycle.
  assign w_pop  = i_pop && (r_count != 2'd0);
  assign w_push = i_push && ((r_count != 2'd2) || w_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_row;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule : comb_row_fifo

`default_nettype wire

// File: rtl/comb_row_reader.sv
// ============================================================================
// Module      : comb_row_reader
// Description : Drains completed rows of the combination result buffer, in
//               order, onto a valid/ready stream towards aggregation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module comb_row_reader
  import comb_pkg::*;
#(
  parameter int COO_NUM_OF_COLS = 6,
  parameter int COO_BW          = $clog2(COO_NUM_OF_COLS),
  parameter int WM_NUM_OF_COLS  = 3,
  parameter int DOT_PROD_WIDTH  = 16
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic [COO_BW:0]                        comb_rows_written,
  output logic                                   read_en,
  output logic [COO_BW-1:0]                      read_addr,
  input  logic [WM_NUM_OF_COLS*DOT_PROD_WIDTH-1:0] read_data,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [WM_NUM_OF_COLS*DOT_PROD_WIDTH-1:0] out_data,
  output logic [COO_BW-1:0]                      out_row_idx,
  output logic                                   done
);

  localparam logic [COO_BW-1:0] C_LAST_ROW = COO_BW'(COO_NUM_OF_COLS - 1);

  comb_rd_state_t    r_state;
  comb_rd_state_t    w_state_nxt;
  logic [COO_BW-1:0] r_rd_ptr;
  logic [COO_BW-1:0] r_tag;
  logic              r_issued_all;
  logic              r_inflight;

  logic              w_fire;
  logic              w_issue;
  logic              w_room;
  logic [2:0]        w_occ;
  logic [1:0]        w_count;
  comb_row_t         w_push_row;
  comb_row_t         w_head;

  assign w_fire = out_valid & out_ready;

  // Entries held plus the row still in the buffer pipeline must fit in two slots.
  assign w_occ  = {1'b0, w_count} + {2'b00, r_inflight};
  assign w_room = (w_occ < 3'd2) || (w_fire && (w_occ == 3'd2));

  assign w_issue = (r_state == RUN) && !r_issued_all
                && ({1'b0, r_rd_ptr} < comb_rows_written) && w_room;

  assign read_en   = w_issue;
  assign read_addr = r_rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        // Leave as the last row is popped so done follows the final fire directly.
        if (r_issued_all && !r_inflight && (w_count == {1'b0, w_fire})) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr     <= '0;
      r_tag        <= '0;
      r_issued_all <= 1'b0;
      r_inflight   <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if ((r_state == IDLE) && start) begin
        r_rd_ptr     <= '0;
        r_issued_all <= 1'b0;
      end else if (w_issue) begin
        r_tag <= r_rd_ptr;
        if (r_rd_ptr == C_LAST_ROW) begin
          r_rd_ptr     <= '0;
          r_issued_all <= 1'b1;
        end else begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
      end
    end
  end

  assign w_push_row.data = read_data;
  assign w_push_row.idx  = r_tag;

  comb_row_fifo u_row_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (r_inflight),
    .i_push_row (w_push_row),
    .i_pop      (w_fire),
    .o_head     (w_head),
    .o_count    (w_count)
  );

  assign out_valid   = (w_count != 2'd0);
  assign out_data    = w_head.data;
  assign out_row_idx = w_head.idx;

endmodule : comb_row_reader

`default_nettype wire

// File: tb/tb_comb_row_reader.sv
// ============================================================================
// Module      : tb_comb_row_reader
// Description : Directed self-checking bench for comb_row_reader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_comb_row_reader;

  localparam int NROWS = 6;
  localparam int BW    = 3;
  localparam int RW    = 48;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [BW:0]   comb_rows_written;
  logic          read_en;
  logic [BW-1:0] read_addr;
  logic [RW-1:0] read_data;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_data;
  logic [BW-1:0] out_row_idx;
  logic          done;

  logic [RW-1:0] mem [NROWS];

  int n_checks = 0;
  int n_fail   = 0;
  int seed     = 0;
  int exp_idx  = 0;
  int done_cnt = 0;

  logic          prev_hold = 1'b0;
  logic [51:0]   prev_out  = '0;

  always #5 clk = ~clk;

  // Result buffer model: one-cycle read latency.
  always @(posedge clk) begin
    if (read_en) read_data <= mem[read_addr];
  end

  comb_row_reader #(
    .COO_NUM_OF_COLS (NROWS),
    .COO_BW          (BW),
    .WM_NUM_OF_COLS  (3),
    .DOT_PROD_WIDTH  (16)
  ) u_dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .comb_rows_written (comb_rows_written),
    .read_en           (read_en),
    .read_addr         (read_addr),
    .read_data         (read_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_data          (out_data),
    .out_row_idx       (out_row_idx),
    .done              (done)
  );

  function automatic logic [RW-1:0] row_val(int s, int r);
    logic [15:0] b;
    b = 16'(s * 256 + r * 16);
    return {b + 16'd2, b + 16'd1, b};
  endfunction

  task automatic fill_mem(int s);
    seed = s;
    for (int r = 0; r < NROWS; r++) mem[r] = row_val(s, r);
  endtask

  task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Checks the current cycle with its final inputs, then advances one clock.
  task automatic cycle();
    if (!reset) begin
      if (prev_hold) check_eq("hold_stable", {out_valid, out_row_idx, out_data}, prev_out);
      if (read_en) check_eq("read_gated", {63'd0, ({1'b0, read_addr} < comb_rows_written)}, 64'd1);
      if (out_valid && out_ready) begin
        check_eq("row_idx", out_row_idx, exp_idx[BW-1:0]);
        check_eq("row_data", out_data, row_val(seed, exp_idx));
        exp_idx++;
      end
      if (done) done_cnt++;
      prev_hold = out_valid && !out_ready;
      prev_out  = {out_valid, out_row_idx, out_data};
    end else begin
      prev_hold = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic begin_pass(int s, logic [BW:0] rows);
    fill_mem(s);
    comb_rows_written = rows;
    exp_idx  = 0;
    done_cnt = 0;
    start    = 1'b1;
    cycle();
    start    = 1'b0;
  endtask

  task automatic finish_pass(string tag, int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) cycle();
    check_eq({tag, "_done"}, done_cnt, 1);
    check_eq({tag, "_rows"}, exp_idx, NROWS);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    comb_rows_written = '0;
    fill_mem(0);
    @(negedge clk);
    repeat (3) cycle();
    reset = 1'b0;
    check_eq("rst_read_en", read_en, 0);
    check_eq("rst_read_addr", read_addr, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_out_row_idx", out_row_idx, 0);
    check_eq("rst_done", done, 0);
    cycle();

    // Pre-filled buffer, always ready: exact cycle timing.
    out_ready = 1'b1;
    begin_pass(1, 4'd6);
    for (int k = 1; k <= 10; k++) begin
      check_eq("t1_read_en", read_en, (k <= 6) ? 1 : 0);
      if (k <= 6) check_eq("t1_read_addr", read_addr, k - 1);
      check_eq("t1_out_valid", out_valid, (k >= 3 && k <= 8) ? 1 : 0);
      check_eq("t1_done", done, (k == 9) ? 1 : 0);
      cycle();
    end
    check_eq("t1_rows", exp_idx, NROWS);

    // Writer releases one row every 4 cycles.
    begin_pass(2, 4'd0);
    for (int i = 0; i < 80 && done_cnt == 0; i++) begin
      comb_rows_written = ((i / 4) > NROWS) ? 4'(NROWS) : 4'(i / 4);
      if (i == 2) check_eq("t2_no_read_rows0", read_en, 0);
      cycle();
    end
    check_eq("t2_done", done_cnt, 1);
    check_eq("t2_rows", exp_idx, NROWS);

    // Back-pressure for 10 cycles mid-pass.
    out_ready = 1'b1;
    begin_pass(3, 4'd6);
    repeat (3) cycle();
    out_ready = 1'b0;
    for (int j = 0; j < 10; j++) begin
      if (j == 9) begin
        check_eq("t3_stall_read_en", read_en, 0);
        check_eq("t3_stall_valid", out_valid, 1);
      end
      cycle();
    end
    out_ready = 1'b1;
    finish_pass("t3", 40);

    // Three back-to-back passes with random ready and a stray start in RUN.
    for (int p = 0; p < 3; p++) begin
      out_ready = 1'($urandom_range(0, 1));
      begin_pass(4 + p, 4'd6);
      for (int i = 0; i < 200 && done_cnt == 0; i++) begin
        out_ready = 1'($urandom_range(0, 1));
        start = (i == 5);
        cycle();
      end
      start = 1'b0;
      check_eq("t4_done", done_cnt, 1);
      check_eq("t4_rows", exp_idx, NROWS);
    end

    // Reset the cycle after a read issue, then restart cleanly.
    out_ready = 1'b1;
    begin_pass(8, 4'd6);
    check_eq("t5_first_read", read_en, 1);
    check_eq("t5_first_addr", read_addr, 0);
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check_eq("t5_rst_read_en", read_en, 0);
    check_eq("t5_rst_read_addr", read_addr, 0);
    check_eq("t5_rst_out_valid", out_valid, 0);
    check_eq("t5_rst_out_data", out_data, 0);
    check_eq("t5_rst_out_row_idx", out_row_idx, 0);
    check_eq("t5_rst_done", done, 0);
    begin_pass(9, 4'd6);
    check_eq("t5_restart_read", read_en, 1);
    check_eq("t5_restart_addr", read_addr, 0);
    check_eq("t5_restart_no_stale", out_valid, 0);
    finish_pass("t5", 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_comb_row_reader

`default_nettype wire
